// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if: operand stream in, result handshake out
interface csa_accum_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] Sum;
    logic                 Co;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, Sum, Co);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, Sum, Co);
endinterface

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: serial carry-save multi-operand accumulator, optional abort via CSA_ACCUM_ABORT_EN
module csa_accum_ctrl #(
    parameter int WIDTH     = 8,
    parameter int NUM_OPS   = 10,
    parameter int OUT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef CSA_ACCUM_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic [7:0]            op_count,
    csa_accum_ctrl_if.slave       bus
);
    localparam int W = OUT_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
    state_t state, nxt;
    logic [W-1:0] s, c, x;
    logic hs, last, kill;
    assign x = W'(bus.in_data);
`ifdef CSA_ACCUM_ABORT_EN
    assign kill = abort && (state == ACCUM || state == RESOLVE);
`else
    assign kill = 1'b0;
`endif
    // an aborted cycle's handshake is dropped
    assign hs   = bus.in_valid && bus.in_ready && !kill;
    assign last = hs && op_count == 8'(NUM_OPS - 1);
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? ACCUM : IDLE;
            ACCUM:   nxt = last ? RESOLVE : ACCUM;
            RESOLVE: nxt = DONE;
            DONE:    nxt = bus.out_ready ? IDLE : DONE;
        endcase
        if (kill) nxt = IDLE;
    end
    always_comb begin
        bus.in_ready  = state == ACCUM;
        bus.out_valid = state == DONE;
        busy          = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= '0;
            c        <= '0;
            op_count <= '0;
            bus.Sum  <= '0;
            bus.Co   <= 1'b0;
        end else if (kill || (state == IDLE && start)) begin
            s        <= '0;
            c        <= '0;
            op_count <= '0;
        end else if (hs) begin
            s        <= s ^ c ^ x;
            c        <= ((s & c) | (s & x) | (c & x)) << 1;
            op_count <= op_count + 8'd1;
        end else if (state == RESOLVE) begin
            {bus.Co, bus.Sum} <= s + c;
        end
    end
endmodule
